// File: rtl/ava_rx_sched.sv
// ava_rx_sched: sequences NUM_CH ava_rx nonce receivers and merges their
// nonces into a single report stream.
//
// Ports:
//   clk             system clock, all logic on posedge
//   global_reset_n  asynchronous active-low reset
//   work_start      per-channel pulse: work was just sent to that chip
//   rx_en           per-channel receiver enable (listen window)
//   rx_ready        per-channel one-cycle nonce-ready pulse from ava_rx
//   rx_data         flattened ava_rx data, channel i at [i*NONCE_SIZE +: NONCE_SIZE]
//   nonce_valid     FIFO head valid (show-ahead)
//   nonce_ready     consumer accepts the head this cycle
//   nonce_data      FIFO head nonce
//   nonce_ch        source channel of the FIFO head
//   fifo_count      current FIFO occupancy
//   drop_cnt        saturating count of lost nonces
module ava_rx_sched #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CH_W           = 2,
    parameter int unsigned NONCE_SIZE     = 32,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic                           clk,
    input  logic                           global_reset_n,
    input  logic [NUM_CH-1:0]              work_start,
    output logic [NUM_CH-1:0]              rx_en,
    input  logic [NUM_CH-1:0]              rx_ready,
    input  logic [NUM_CH*NONCE_SIZE-1:0]   rx_data,
    output logic                           nonce_valid,
    input  logic                           nonce_ready,
    output logic [NONCE_SIZE-1:0]          nonce_data,
    output logic [CH_W-1:0]                nonce_ch,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic [7:0]                     drop_cnt
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = AW + 1;
    localparam int unsigned ENT_W = CH_W + NONCE_SIZE;

    typedef enum logic [1:0] {
        StIdle,
        StListen,
        StRearm
    } ch_state_e;

    // ------------------------------------------------------------------
    // Per-channel listen-window FSM
    // ------------------------------------------------------------------
    ch_state_e   state_q [NUM_CH];
    ch_state_e   state_d [NUM_CH];
    logic [23:0] timer_q [NUM_CH];
    logic [23:0] timer_d [NUM_CH];

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= StIdle;
                timer_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            rx_en[i]   = 1'b0;
            case (state_q[i])
                StIdle: begin
                    if (work_start[i]) begin
                        state_d[i] = StListen;
                        timer_d[i] = TIMEOUT_CYCLES;
                    end
                end
                StListen: begin
                    rx_en[i] = 1'b1;
                    if (work_start[i]) begin
                        // One low cycle forces a fresh enable edge in ava_rx.
                        state_d[i] = StRearm;
                        timer_d[i] = TIMEOUT_CYCLES;
                    end else begin
                        timer_d[i] = timer_q[i] - 24'd1;
                        if (timer_q[i] == 24'd1) begin
                            state_d[i] = StIdle;
                        end
                    end
                end
                StRearm: begin
                    // Reload already pending; a further work_start is ignored.
                    state_d[i] = StListen;
                    timer_d[i] = TIMEOUT_CYCLES;
                end
                default: begin
                    state_d[i] = StIdle;
                    timer_d[i] = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Hold registers and round-robin arbiter
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0]     pend_q, pend_d;
    logic [NONCE_SIZE-1:0] hold_q [NUM_CH];
    logic [NONCE_SIZE-1:0] hold_d [NUM_CH];
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [7:0]            drop_q, drop_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  fifo_full;
    logic                  gnt_valid;
    logic [CH_W-1:0]       gnt_ch;
    logic [NUM_CH-1:0]     gnt_oh;
    logic [NONCE_SIZE-1:0] gnt_data;
    logic [3:0]            n_drop;
    logic [8:0]            drop_sum;

    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));

    // Two passes: channels at or above rr_ptr first, then the wrapped ones.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_ch    = '0;
        gnt_oh    = '0;
        gnt_data  = '0;
        if (!fifo_full) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!gnt_valid && pend_q[i] && (i >= int'(rr_ptr_q))) begin
                    gnt_valid = 1'b1;
                    gnt_ch    = CH_W'(i);
                    gnt_oh[i] = 1'b1;
                    gnt_data  = hold_q[i];
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (!gnt_valid && pend_q[i] && (i < int'(rr_ptr_q))) begin
                    gnt_valid = 1'b1;
                    gnt_ch    = CH_W'(i);
                    gnt_oh[i] = 1'b1;
                    gnt_data  = hold_q[i];
                end
            end
        end
    end

    always_comb begin
        pend_d   = pend_q;
        n_drop   = '0;
        rr_ptr_d = rr_ptr_q;
        for (int i = 0; i < NUM_CH; i++) begin
            hold_d[i] = hold_q[i];
            if (rx_ready[i]) begin
                if (pend_q[i] && !gnt_oh[i]) begin
                    n_drop = n_drop + 4'd1;
                end else begin
                    // Granted value leaves this cycle, so the slot is free.
                    pend_d[i] = 1'b1;
                    hold_d[i] = rx_data[i*NONCE_SIZE +: NONCE_SIZE];
                end
            end else if (gnt_oh[i]) begin
                pend_d[i] = 1'b0;
            end
        end
        if (gnt_valid) begin
            rr_ptr_d = (int'(gnt_ch) == int'(NUM_CH) - 1) ? '0 : gnt_ch + 1'b1;
        end
        drop_sum = {1'b0, drop_q} + {5'd0, n_drop};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            pend_q   <= '0;
            rr_ptr_q <= '0;
            drop_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            pend_q   <= pend_d;
            rr_ptr_q <= rr_ptr_d;
            drop_q   <= drop_d;
            for (int i = 0; i < NUM_CH; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead nonce FIFO
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic             push, pop;

    assign push = gnt_valid;
    assign pop  = nonce_valid && nonce_ready;

    always_comb begin
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {gnt_ch, gnt_data};
        end
    end

    assign nonce_valid            = (count_q != '0);
    assign {nonce_ch, nonce_data} = mem[rd_ptr_q];
    assign fifo_count             = count_q;
    assign drop_cnt               = drop_q;

endmodule

// File: tb/tb_ava_rx_sched.sv
// Self-checking bench for ava_rx_sched with a transaction-level reference model.
module tb_ava_rx_sched;

    localparam int NCH   = 4;
    localparam int NS    = 32;
    localparam int T     = 10;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            global_reset_n;
    logic [3:0]      work_start;
    logic [3:0]      rx_en;
    logic [3:0]      rx_ready;
    logic [127:0]    rx_data;
    logic            nonce_valid;
    logic            nonce_ready;
    logic [31:0]     nonce_data;
    logic [1:0]      nonce_ch;
    logic [3:0]      fifo_count;
    logic [7:0]      drop_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    always #5 clk = ~clk;

    ava_rx_sched #(
        .NUM_CH         (NCH),
        .CH_W           (2),
        .NONCE_SIZE     (NS),
        .TIMEOUT_CYCLES (24'd10),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk            (clk),
        .global_reset_n (global_reset_n),
        .work_start     (work_start),
        .rx_en          (rx_en),
        .rx_ready       (rx_ready),
        .rx_data        (rx_data),
        .nonce_valid    (nonce_valid),
        .nonce_ready    (nonce_ready),
        .nonce_data     (nonce_data),
        .nonce_ch       (nonce_ch),
        .fifo_count     (fifo_count),
        .drop_cnt       (drop_cnt)
    );

    // Reference model: listen windows as [start, end] cycle ranges, nonces as
    // pending slots plus a queue.
    int          m_ws [NCH];
    int          m_we [NCH];
    bit [3:0]    m_pend;
    logic [31:0] m_hold [NCH];
    logic [33:0] m_fifo [$];
    int          m_rr;
    int          m_drop;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_ws[c]   = 1 << 30;
            m_we[c]   = -1;
            m_hold[c] = '0;
        end
        m_pend = '0;
        m_fifo.delete();
        m_rr   = 0;
        m_drop = 0;
    endtask

    function automatic logic [3:0] model_en();
        logic [3:0] e;
        for (int c = 0; c < NCH; c++) e[c] = (cyc >= m_ws[c]) && (cyc <= m_we[c]);
        return e;
    endfunction

    task automatic model_step(input logic [3:0] ws, input logic [3:0] rdy,
                              input logic [127:0] data, input logic nrdy);
        int g;
        bit full;
        for (int c = 0; c < NCH; c++) begin
            if (ws[c]) begin
                if (cyc >= m_ws[c] && cyc <= m_we[c]) begin
                    m_ws[c] = cyc + 2;          // one low cycle, then a full window
                    m_we[c] = cyc + 1 + T;
                end else if (cyc != m_ws[c] - 1) begin
                    m_ws[c] = cyc + 1;
                    m_we[c] = cyc + T;
                end
            end
        end
        full = (m_fifo.size() == DEPTH);
        if (m_fifo.size() > 0 && nrdy) void'(m_fifo.pop_front());
        g = -1;
        if (!full) begin
            for (int k = 0; k < NCH; k++) begin
                if (g < 0 && m_pend[(m_rr + k) % NCH]) g = (m_rr + k) % NCH;
            end
        end
        if (g >= 0) begin
            m_fifo.push_back({2'(g), m_hold[g]});
            m_pend[g] = 1'b0;
            m_rr = (g + 1) % NCH;
        end
        for (int c = 0; c < NCH; c++) begin
            if (rdy[c]) begin
                if (m_pend[c]) begin
                    m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                end else begin
                    m_pend[c] = 1'b1;
                    m_hold[c] = data[c*NS +: NS];
                end
            end
        end
    endtask

    task automatic tick(input logic [3:0] ws, input logic [3:0] rdy,
                        input logic [127:0] data, input logic nrdy);
        work_start  = ws;
        rx_ready    = rdy;
        rx_data     = data;
        nonce_ready = nrdy;
        model_step(ws, rdy, data, nrdy);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        global_reset_n = 1'b0;
        work_start     = '0;
        rx_ready       = '0;
        rx_data        = '0;
        nonce_ready    = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        cyc++;
        global_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (rx_en !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_rx_en got %b want 0000", rx_en);
        end
        tests_run++;
        if (nonce_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid got %b want 0", nonce_valid);
        end
        tests_run++;
        if (fifo_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_count got %0d want 0", fifo_count);
        end
        tests_run++;
        if (drop_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_drop got %0d want 0", drop_cnt);
        end
    endtask

    task automatic test_enable_window();
        logic [3:0] exp;
        do_reset();
        tick(4'b0001, 4'b0000, '0, 1'b0);       // cycle 0
        for (int k = 1; k <= 14; k++) begin
            exp = (k >= 1 && k <= 10) ? 4'b0001 : 4'b0000;
            tests_run++;
            if (rx_en !== exp) begin
                tests_failed++;
                $display("FAIL enable_window k=%0d got %b want %b", k, rx_en, exp);
            end
            tick(4'b0000, 4'b0000, '0, 1'b0);
        end
    endtask

    task automatic test_rearm();
        logic [3:0] exp;
        do_reset();
        tick(4'b0100, 4'b0000, '0, 1'b0);       // cycle 0
        for (int k = 1; k <= 20; k++) begin
            exp = ((k >= 1 && k <= 5) || (k >= 7 && k <= 16)) ? 4'b0100 : 4'b0000;
            tests_run++;
            if (rx_en !== exp) begin
                tests_failed++;
                $display("FAIL rearm k=%0d got %b want %b", k, rx_en, exp);
            end
            // Second pulse lands in the low cycle and must be ignored.
            tick((k == 5 || k == 6) ? 4'b0100 : 4'b0000, 4'b0000, '0, 1'b0);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0]  got_ch [$];
        logic [31:0] got_d [$];
        int          got_c [$];
        int          c0;
        do_reset();
        c0 = cyc;
        tick(4'b0000, 4'b1011, {32'h33333333, 32'h0, 32'h22222222, 32'h11111111}, 1'b1);
        for (int k = 0; k < 10; k++) begin
            if (nonce_valid) begin
                got_ch.push_back(nonce_ch);
                got_d.push_back(nonce_data);
                got_c.push_back(cyc);
            end
            tick(4'b0000, 4'b0000, '0, 1'b1);
        end
        tests_run++;
        if (got_ch.size() != 3) begin
            tests_failed++;
            $display("FAIL simul_count got %0d want 3", got_ch.size());
        end else begin
            tests_run++;
            if ({got_ch[0], got_d[0]} !== {2'd0, 32'h11111111}) begin
                tests_failed++;
                $display("FAIL simul_0 got ch%0d %h want ch0 11111111", got_ch[0], got_d[0]);
            end
            tests_run++;
            if ({got_ch[1], got_d[1]} !== {2'd1, 32'h22222222}) begin
                tests_failed++;
                $display("FAIL simul_1 got ch%0d %h want ch1 22222222", got_ch[1], got_d[1]);
            end
            tests_run++;
            if ({got_ch[2], got_d[2]} !== {2'd3, 32'h33333333}) begin
                tests_failed++;
                $display("FAIL simul_2 got ch%0d %h want ch3 33333333", got_ch[2], got_d[2]);
            end
            tests_run++;
            if (got_c[0] != c0 + 2 || got_c[2] != c0 + 4) begin
                tests_failed++;
                $display("FAIL simul_timing got %0d..%0d want %0d..%0d",
                         got_c[0], got_c[2], c0 + 2, c0 + 4);
            end
        end
        tests_run++;
        if (drop_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL simul_drop got %0d want 0", drop_cnt);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  got_ch [$];
        logic [31:0] got_d [$];
        do_reset();
        tick(4'b0000, 4'b0010, {64'h0, 32'hAAAA0001, 32'h0}, 1'b1);
        for (int k = 0; k < 4; k++) tick(4'b0000, 4'b0000, '0, 1'b1);
        tick(4'b0000, 4'b0011, {64'h0, 32'hB1B1B1B1, 32'hB0B0B0B0}, 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (nonce_valid) begin
                got_ch.push_back(nonce_ch);
                got_d.push_back(nonce_data);
            end
            tick(4'b0000, 4'b0000, '0, 1'b1);
        end
        tests_run++;
        if (got_ch.size() != 2) begin
            tests_failed++;
            $display("FAIL rr_count got %0d want 2", got_ch.size());
        end else begin
            tests_run++;
            if ({got_ch[0], got_d[0]} !== {2'd0, 32'hB0B0B0B0}) begin
                tests_failed++;
                $display("FAIL rr_first got ch%0d %h want ch0 b0b0b0b0", got_ch[0], got_d[0]);
            end
            tests_run++;
            if ({got_ch[1], got_d[1]} !== {2'd1, 32'hB1B1B1B1}) begin
                tests_failed++;
                $display("FAIL rr_second got ch%0d %h want ch1 b1b1b1b1", got_ch[1], got_d[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got_d [$];
        logic [1:0]  got_ch [$];
        logic [31:0] v;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            v = 32'hA0000000 + 32'(k);
            tick(4'b0000, 4'b0001, {96'h0, v}, 1'b0);
            tick(4'b0000, 4'b0000, '0, 1'b0);
            tick(4'b0000, 4'b0000, '0, 1'b0);
        end
        tick(4'b0000, 4'b0000, '0, 1'b0);
        tests_run++;
        if (fifo_count !== 4'd8) begin
            tests_failed++;
            $display("FAIL bp_full_count got %0d want 8", fifo_count);
        end
        tests_run++;
        if (drop_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL bp_drop got %0d want 1", drop_cnt);
        end
        for (int k = 0; k < 30; k++) begin
            if (nonce_valid) begin
                got_d.push_back(nonce_data);
                got_ch.push_back(nonce_ch);
            end
            tick(4'b0000, 4'b0000, '0, 1'b1);
        end
        tests_run++;
        if (got_d.size() != 9) begin
            tests_failed++;
            $display("FAIL bp_emitted got %0d want 9", got_d.size());
        end
        for (int k = 0; k < got_d.size() && k < 9; k++) begin
            v = 32'hA0000000 + 32'(k);
            tests_run++;
            if (got_d[k] !== v || got_ch[k] !== 2'd0) begin
                tests_failed++;
                $display("FAIL bp_order k=%0d got ch%0d %h want ch0 %h", k, got_ch[k], got_d[k], v);
            end
        end
    endtask

    task automatic test_drop_saturate();
        logic [127:0] d;
        do_reset();
        for (int k = 0; k < 100; k++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            tick(4'b0000, 4'b1111, d, 1'b0);
            tests_run++;
            if (drop_cnt !== 8'(m_drop)) begin
                tests_failed++;
                $display("FAIL sat_track k=%0d got %0d want %0d", k, drop_cnt, m_drop);
            end
        end
        tests_run++;
        if (drop_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL sat_final got %0d want 255", drop_cnt);
        end
    endtask

    task automatic test_random();
        logic [3:0]   ws, rdy;
        logic [127:0] d;
        logic         nrdy;
        logic [33:0]  h;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < NCH; c++) begin
                ws[c]  = ($urandom_range(15) == 0);
                rdy[c] = ($urandom_range(3) == 0);
            end
            d    = {$urandom, $urandom, $urandom, $urandom};
            nrdy = (k % 100 < 50) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            tick(ws, rdy, d, nrdy);
            tests_run++;
            if (rx_en !== model_en()) begin
                tests_failed++;
                $display("FAIL rand_en k=%0d got %b want %b", k, rx_en, model_en());
            end
            tests_run++;
            if (fifo_count !== 4'(m_fifo.size()) || nonce_valid !== (m_fifo.size() != 0)) begin
                tests_failed++;
                $display("FAIL rand_count k=%0d got %0d/%b want %0d", k, fifo_count,
                         nonce_valid, m_fifo.size());
            end
            tests_run++;
            if (drop_cnt !== 8'(m_drop)) begin
                tests_failed++;
                $display("FAIL rand_drop k=%0d got %0d want %0d", k, drop_cnt, m_drop);
            end
            if (m_fifo.size() != 0) begin
                h = m_fifo[0];
                tests_run++;
                if ({nonce_ch, nonce_data} !== h) begin
                    tests_failed++;
                    $display("FAIL rand_head k=%0d got ch%0d %h want ch%0d %h", k, nonce_ch,
                             nonce_data, h[33:32], h[31:0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(4'b0101, 4'b0000, '0, 1'b0);
        tick(4'b0000, 4'b0001, {96'h0, 32'hC0}, 1'b0);
        tick(4'b0000, 4'b0010, {64'h0, 32'hC1, 32'h0}, 1'b0);
        tick(4'b0000, 4'b0100, {32'h0, 32'hC2, 64'h0}, 1'b0);
        tick(4'b0000, 4'b1000, {32'hC3, 96'h0}, 1'b0);
        tick(4'b0000, 4'b0001, {96'h0, 32'hC4}, 1'b0);
        tick(4'b0000, 4'b0000, '0, 1'b0);
        tick(4'b0000, 4'b0000, '0, 1'b0);
        tests_run++;
        if (fifo_count !== 4'd5 || rx_en !== 4'b0101) begin
            tests_failed++;
            $display("FAIL mid_pre got count %0d en %b want 5 0101", fifo_count, rx_en);
        end
        #2 global_reset_n = 1'b0;
        #1;
        tests_run++;
        if (nonce_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_valid got %b want 0", nonce_valid);
        end
        tests_run++;
        if (rx_en !== 4'b0000) begin
            tests_failed++;
            $display("FAIL mid_en got %b want 0000", rx_en);
        end
        tests_run++;
        if (fifo_count !== 4'd0 || drop_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL mid_count got %0d drop %0d want 0 0", fifo_count, drop_cnt);
        end
        model_reset();
        @(negedge clk);
        cyc++;
        global_reset_n = 1'b1;
    endtask

    initial begin
        global_reset_n = 1'b0;
        work_start     = '0;
        rx_ready       = '0;
        rx_data        = '0;
        nonce_ready    = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_enable_window();
        test_rearm();
        test_simultaneous();
        test_round_robin();
        test_backpressure();
        test_drop_saturate();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ava_rx_sched.md
Name: ava_rx_sched

Overview:
- Sequences and shares NUM_CH ava_rx nonce receivers, one per chip channel.
- Per channel: drives the receiver enable window after work is dispatched, and re-arms it when new work arrives mid-window.
- Captures each one-cycle ready pulse into a per-channel hold register.
- Drains the hold registers round-robin into one nonce FIFO that feeds the report path over a valid/ready handshake.

Parameters:
- NUM_CH, 4, number of ava_rx channels (2..8).
- CH_W, 2, channel index width; 2**CH_W >= NUM_CH.
- NONCE_SIZE, 32, nonce width; must match the ava_rx instances.
- TIMEOUT_CYCLES, 24'd1000000, listen window length in clk cycles (>= 2).
- FIFO_DEPTH, 8, nonce FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, all logic on posedge.
- global_reset_n  in  1  asynchronous, active-low reset.
- work_start  in  NUM_CH  one-cycle pulse per channel: work was just sent to that chip.
- rx_en  out  NUM_CH  enable to each ava_rx.
- rx_ready  in  NUM_CH  ready pulse from each ava_rx.
- rx_data  in  NUM_CH*NONCE_SIZE  flattened ava_rx data; channel i occupies bits [i*NONCE_SIZE +: NONCE_SIZE].
- nonce_valid  out  1  FIFO head is valid.
- nonce_ready  in  1  consumer accepts the head this cycle.
- nonce_data  out  NONCE_SIZE  FIFO head nonce.
- nonce_ch  out  CH_W  source channel of the head.
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- drop_cnt  out  8  nonces lost to hold overrun or FIFO full; saturates at 255.

Behaviour:
- Reset (async assert, sync release): rx_en=0, all timers=0, all channels IDLE, pend=0, rr_ptr=0, FIFO empty, nonce_valid=0, drop_cnt=0.
- nonce_data/nonce_ch are don't-care while nonce_valid=0.
- Per-channel FSM states:
  - IDLE: on work_start[i] go to LISTEN, timer=TIMEOUT_CYCLES; rx_en[i]=1 from the next cycle.
  - LISTEN: timer decrements each cycle. When timer reaches 1, next state is IDLE and rx_en[i]=0.
  - LISTEN + work_start[i]: go to REARM for exactly one cycle with rx_en[i]=0, then LISTEN with timer reloaded to TIMEOUT_CYCLES. The low cycle guarantees an en rising edge, which clears the ava_rx bit counter.
  - REARM + work_start[i]: ignored (reload already pending).
  - Captured nonces never end the listen window.
- Capture:
  - rx_ready[i]=1 at an edge sets pend[i]=1 and loads hold[i]=rx_data slice i.
  - Capture happens regardless of FSM state.
  - If pend[i] is still 1 and not being granted that cycle: the new nonce is dropped, hold[i] is unchanged, drop_cnt+1.
  - If pend[i] is being granted that same cycle: the granted (old) value goes to the FIFO, the new value loads hold[i], and pend[i] stays 1. Nothing is lost.
- Arbiter:
  - Each cycle, if any pend bit is set and the FIFO is not full, grant the first pending channel searching from rr_ptr upward, with wrap.
  - On grant: write {channel, hold} to the FIFO, clear pend (unless recaptured that cycle), rr_ptr = granted+1 mod NUM_CH.
  - At most one grant per cycle.
  - FIFO full: no grant, pend bits held, no drop (drop only on hold overrun).
  - rr_ptr changes only on a grant.
- FIFO:
  - Show-ahead: nonce_valid = (count != 0); nonce_data/nonce_ch come from the head entry.
  - Pop on nonce_valid && nonce_ready.
  - "Full" is evaluated on the pre-edge count; a push is blocked when full even if a pop happens in the same cycle.
  - Push and pop in the same cycle when not full: count unchanged.
  - Pointers wrap mod FIFO_DEPTH.
- Latency: rx_ready high in cycle T (FIFO empty, no contention) gives pend in T+1, write at end of T+1, nonce_valid in T+2.
- drop_cnt: increments once per lost nonce; two simultaneous drops in one cycle add 2; saturates at 255, never wraps.
- Reset mid-operation: everything returns to reset values immediately; in-flight nonces are discarded and not counted.

Test Plan:
- Enable window: TIMEOUT_CYCLES=10, work_start[0] pulse at cycle 0 -> rx_en[0]=1 for cycles 1..10, 0 at cycle 11; rx_en[1..3] stay 0.
- Re-arm: work_start[2] at cycle 0, again at cycle 5 -> rx_en[2]=1 for cycles 1..5, 0 at cycle 6, 1 again from cycle 7 for 10 cycles.
- Simultaneous nonces: rx_ready=4'b1011 in one cycle, data ch0=0x11111111, ch1=0x22222222, ch3=0x33333333, rr_ptr=0, nonce_ready=1 -> outputs in order (ch0,0x11111111), (ch1,0x22222222), (ch3,0x33333333) on consecutive cycles; drop_cnt=0.
- Round-robin fairness: after granting ch1, ch1 and ch0 both pending -> ch0 granted before ch1.
- Backpressure/full: nonce_ready=0, FIFO_DEPTH=8, 10 nonces from ch0 spaced 3 cycles apart -> fifo_count=8, one nonce held in hold, remaining one dropped, drop_cnt=1; raise nonce_ready -> 9 nonces emitted in arrival order.
- Reset mid-stream: assert global_reset_n=0 with fifo_count=5 and rx_en=4'b0101 -> within the same cycle nonce_valid=0, rx_en=0, fifo_count=0, drop_cnt=0.
